// File: rtl/computer_player_pkg.sv
// Shared types and constants for the computer player: FSM state encoding,
// LFSR width, default timing parameters and the LFSR step function.
package computer_player_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam int LFSR_W             = 10;
  localparam int HOLD_DEFAULT       = 4;
  localparam int COOLDOWN_DEFAULT   = 4;
  localparam int SAMPLE_DIV_DEFAULT = 1;

  // XNOR feedback keeps the all-zero state legal, so reset to 0 works;
  // the all-ones word is the lock-up state and can never be reached.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ~(v[9] ^ v[6])};
  endfunction

endpackage

// File: rtl/computer_player_lfsr10.sv
// Free-running 10-bit XNOR LFSR used as the press decision source.
// It advances every clock regardless of enable.
module lfsr10
  import computer_player_pkg::*;
(
  input  logic              clk,
  input  logic              Reset,
  output logic [LFSR_W-1:0] q
);

  // Shift register; restarts at 0 on reset, giving 0,1,3,7,... afterwards
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) q <= '0;
    else       q <= lfsr_next(q);
  end

endmodule

// File: rtl/computer_player.sv
// Computer player: periodically compares the difficulty switches against a
// pseudo-random value and, when the compare wins, holds the key down for
// HOLD_CYCLES and then keeps it released for COOLDOWN_CYCLES.
// Optional build macro PRESS_COUNT_EN adds a saturating press_count output.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a tick where {0,difficulty} > lfsr
// PRESS    | press held high, cnt counts down remaining hold cycles
// COOLDOWN | press forced low, cnt counts down remaining cooldown cycles
module computer_player
  import computer_player_pkg::*;
#(
  parameter int HOLD_CYCLES     = HOLD_DEFAULT,
  parameter int COOLDOWN_CYCLES = COOLDOWN_DEFAULT,
  parameter int SAMPLE_DIV      = SAMPLE_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic [8:0] difficulty,
  output logic       press,
  output logic       busy
`ifdef PRESS_COUNT_EN
  ,
  output logic [7:0] press_count
`endif
);

  localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]  COOL_LOAD = 8'(COOLDOWN_CYCLES - 1);
  localparam logic [15:0] TICK_LAST = 16'(SAMPLE_DIV - 1);

  logic [LFSR_W-1:0] lfsr;
  logic [15:0]       tick_cnt;
  logic              tick;
  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic              start;

  lfsr10 u_lfsr (
    .clk   (clk),
    .Reset (Reset),
    .q     (lfsr)
  );

  assign tick = enable && (tick_cnt == TICK_LAST);

  // Decision tick divider; only advances while the game is running
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)        tick_cnt <= '0;
    else if (!enable) tick_cnt <= '0;
    else if (tick)    tick_cnt <= '0;
    else              tick_cnt <= tick_cnt + 16'd1;
  end

  // State, hold/cooldown counter and registered key level
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      press <= (state_n == PRESS);
    end
  end

  // Next-state logic; dropping enable aborts from any state
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start   = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tick && ({1'b0, difficulty} > lfsr)) begin
            state_n = PRESS;
            cnt_n   = HOLD_LOAD;
            start   = 1'b1;
          end
        end
        PRESS: begin
          if (cnt == 8'd0) begin
            state_n = COOLDOWN;
            cnt_n   = COOL_LOAD;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
        COOLDOWN: begin
          if (cnt == 8'd0) state_n = IDLE;
          else             cnt_n   = cnt - 8'd1;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef PRESS_COUNT_EN
  logic [7:0] press_cnt_q;

  // Counts IDLE->PRESS transitions, sticking at 255
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)                           press_cnt_q <= '0;
    else if (start && press_cnt_q != 8'hFF) press_cnt_q <= press_cnt_q + 8'd1;
  end

  assign press_count = press_cnt_q;
`else
  logic unused_start;
  assign unused_start = start;
`endif

endmodule

// File: doc/computer_player.md
COMPUTER_PLAYER -- requirements
Module: computer_player

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: number of cycles press is held high per press, range 1..255.
REQ-002 SHALL have parameter COOLDOWN_CYCLES, default 4: number of cycles press is forced low after each press, range 1..255.
REQ-003 SHALL have parameter SAMPLE_DIV, default 1: clock cycles between press decisions, range 1..65535.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-005 SHALL have port Reset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port enable, input, 1 bit: game running; presses are only generated while it is high.
REQ-007 SHALL have port difficulty, input, 9 bits: press threshold from the switches.
REQ-008 SHALL have port press, output, 1 bit: registered key level, driven into the game's two-flop key synchronizer.
REQ-009 SHALL have port busy, output, 1 bit: high while in PRESS or COOLDOWN.

Function
REQ-010 SHALL contain a 10-bit LFSR lfsr that shifts left every clk cycle (enable ignored), new LSB = ~(lfsr[9] ^ lfsr[6]); 0x3FF is unreachable.
REQ-011 SHALL run a tick counter 0..SAMPLE_DIV-1 only while enable=1, cleared to 0 while enable=0, and assert tick in the cycle the counter equals SAMPLE_DIV-1 (with SAMPLE_DIV=1, tick every enabled cycle).
REQ-012 SHALL implement FSM states IDLE, PRESS, COOLDOWN with a down-counter cnt (8 bits).
REQ-013 In IDLE with enable=1 and tick=1 and {1'b0,difficulty} > lfsr: SHALL go to PRESS, load cnt=HOLD_CYCLES-1, press=1 on the next edge (1-cycle latency).
REQ-014 In PRESS: SHALL decrement cnt; at cnt=0 SHALL go to COOLDOWN, load cnt=COOLDOWN_CYCLES-1, press=0; press therefore stays high exactly HOLD_CYCLES cycles.
REQ-015 In COOLDOWN: SHALL decrement cnt; at cnt=0 SHALL go to IDLE; no press is possible before IDLE is reached.
REQ-016 enable=0 in any state SHALL force IDLE and press=0 on the next edge (abort), overriding all other transitions.
REQ-017 difficulty=0 SHALL never produce a press; the comparison is unsigned, 10-bit.
REQ-018 A difficulty change SHALL affect only decisions made in later ticks, never a press or cooldown already in progress.

Reset
REQ-019 Reset=1 SHALL immediately force state=IDLE, press=0, busy=0, lfsr=0, cnt=0, tick counter=0.
REQ-020 Reset asserted mid-PRESS SHALL drop press to 0 without waiting for a clock edge.

Configuration
REQ-021 Macro PRESS_COUNT_EN defined: SHALL add output press_count (8 bits), which increments on every IDLE->PRESS transition, saturates at 255, and is reset to 0 by Reset.
REQ-022 Macro PRESS_COUNT_EN undefined: press_count port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-023 A shared package SHALL hold the state enum (IDLE, PRESS, COOLDOWN), LFSR width 10, and default HOLD/COOLDOWN/SAMPLE_DIV constants.
REQ-024 The LFSR SHALL be a sub-module lfsr10 (clk, Reset, q[9:0]); FSM, tick counter and compare stay in computer_player.

Verification
REQ-025 Reset release, enable=1, difficulty=1, defaults: first tick sees lfsr=0 -> press high exactly cycles 2..5 after release, low for 4 cycles, busy high across all 8 cycles.
REQ-026 difficulty=0, enable=1, 5000 cycles -> press never asserts, busy stays 0.
REQ-027 difficulty=511, mid-PRESS drop enable -> press=0 and state IDLE next edge; re-raise enable -> new press only after a fresh tick with compare true.
REQ-028 SAMPLE_DIV=10, difficulty=511 -> every IDLE->PRESS transition lands on a tick cycle (counter=9); no press within HOLD+COOLDOWN cycles of previous press start.
REQ-029 Async Reset pulse between clock edges during PRESS -> press=0 before the next edge; lfsr restarts 0,1,3,7 after release.
REQ-030 PRESS_COUNT_EN defined, difficulty=511, 300 presses -> press_count reads 255 and holds.
